// File: rtl/axi_fetch_pkg.sv
// Shared types and encodings for the AXI instruction-fetch master:
// FSM states, AXI burst/response codes and line-geometry helpers.
package axi_fetch_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_AR    = 2'd1,
      S_RDATA = 2'd2,
      S_DRAIN = 2'd3
   } fetch_state_e;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

   function automatic int line_bytes(int burst_len, int data_w);
      return burst_len * data_w / 8;
   endfunction

   function automatic logic [2:0] size_enc(int data_w);
      return 3'($clog2(data_w / 8));
   endfunction

endpackage

// File: rtl/fetch_line_buf.sv
// Line storage for one cache line (BURST_LEN beats) plus tag/valid,
// with a combinational 32-bit word read addressed by a fetch PC.
module fetch_line_buf
   import axi_fetch_pkg::*;
#(
   parameter int ADDR_W    = 64,
   parameter int DATA_W    = 64,
   parameter int BURST_LEN = 4,
   localparam int BEAT_OFF = $clog2(DATA_W / 8),
   localparam int LINE_OFF = $clog2(line_bytes(BURST_LEN, DATA_W)),
   localparam int BEAT_W   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1,
   localparam int TAG_W    = ADDR_W - LINE_OFF
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              wr_en_i,
   input  logic [BEAT_W-1:0] wr_idx_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              inval_i,
   input  logic              set_valid_i,
   input  logic [TAG_W-1:0]  set_tag_i,
   input  logic [ADDR_W-1:0] rd_pc_i,
   output logic              hit_o,
   output logic [31:0]       rd_word_o
);

   logic [BURST_LEN-1:0][DATA_W-1:0] mem_q;
   logic [TAG_W-1:0]                 tag_q;
   logic                             valid_q;
   logic [BEAT_W-1:0]                rd_idx;
   logic [BEAT_OFF-3:0]              rd_wsel;
   logic                             unused_bits;

   always_ff @(posedge clk) begin
      if (wr_en_i) mem_q[wr_idx_i] <= wr_data_i;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         valid_q <= 1'b0;
         tag_q   <= '0;
      end else if (inval_i) begin
         valid_q <= 1'b0;
      end else if (set_valid_i) begin
         valid_q <= 1'b1;
         tag_q   <= set_tag_i;
      end
   end

   assign rd_idx      = (BURST_LEN > 1) ? BEAT_W'(rd_pc_i >> BEAT_OFF) : '0;
   assign rd_wsel     = rd_pc_i[BEAT_OFF-1:2];
   assign rd_word_o   = mem_q[rd_idx][{rd_wsel, 5'b0} +: 32];
   assign hit_o       = valid_q && (tag_q == rd_pc_i[ADDR_W-1:LINE_OFF]);
   assign unused_bits = ^rd_pc_i[1:0];

endmodule

// File: rtl/axi_fetch_master.sv
// Instruction-fetch master: one outstanding AXI INCR line fill per miss,
// critical-word response. AXI_FETCH_LINEBUF_EN enables line-buffer hits.
module axi_fetch_master
   import axi_fetch_pkg::*;
#(
   parameter int ADDR_W    = 64,
   parameter int DATA_W    = 64,
   parameter int BURST_LEN = 4,
   parameter int ID_W      = 4,
   parameter int FETCH_ID  = 0
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_pc,
   input  logic              flush,
   output logic              rsp_valid,
   output logic [31:0]       rsp_instr,
   output logic [ADDR_W-1:0] rsp_pc,
   output logic              rsp_err,
   output logic [ID_W-1:0]   ARID,
   output logic [ADDR_W-1:0] ARADDR,
   output logic [7:0]        ARLEN,
   output logic [2:0]        ARSIZE,
   output logic [1:0]        ARBURST,
   output logic              ARVALID,
   input  logic              ARREADY,
   input  logic [ID_W-1:0]   RID,
   input  logic [DATA_W-1:0] RDATA,
   input  logic [1:0]        RRESP,
   input  logic              RLAST,
   input  logic              RVALID,
   output logic              RREADY
);

   localparam int LINE_BYTES = line_bytes(BURST_LEN, DATA_W);
   localparam int BEAT_OFF   = $clog2(DATA_W / 8);
   localparam int LINE_OFF   = $clog2(LINE_BYTES);
   localparam int BEAT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_BYTES - 1);

   fetch_state_e        state_q;
   logic                arvalid_q, rready_q;
   logic                pend_q, err_q, carry_q, flush_seen_q;
   logic [ADDR_W-1:0]   araddr_q, pc_q, rsp_pc_q;
   logic [BEAT_W-1:0]   beat_q;
   logic                rsp_valid_q, rsp_err_q;
   logic [31:0]         rsp_instr_q;

   logic                accept, beat_fire, beat_err, crit_hit, lb_hit, lb_set;
   logic [BEAT_W-1:0]   crit_beat;
   logic [BEAT_OFF-3:0] crit_wsel;
   logic [31:0]         crit_word, lb_word;
   logic                unused_sig;

   assign req_ready = (state_q == S_IDLE) && !flush;
   assign accept    = req_valid && req_ready;
   assign beat_fire = RVALID && rready_q;
   assign beat_err  = RRESP != AXI_RESP_OKAY;
   assign crit_beat = (BURST_LEN > 1) ? BEAT_W'(pc_q >> BEAT_OFF) : '0;
   assign crit_wsel = pc_q[BEAT_OFF-1:2];
   assign crit_word = RDATA[{crit_wsel, 5'b0} +: 32];
   assign crit_hit  = pend_q && (beat_q == crit_beat) && !flush;
   // Only a clean, unflushed fill may later serve hits.
   assign lb_set    = (state_q == S_RDATA) && beat_fire && RLAST && !flush && !err_q && !beat_err;

`ifdef AXI_FETCH_LINEBUF_EN
   assign unused_sig = ^RID;
`else
   assign unused_sig = ^{RID, lb_hit, lb_word};
`endif

   fetch_line_buf #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .BURST_LEN (BURST_LEN)
   ) u_line_buf (
      .clk         (clk),
      .rstn        (rstn),
      .wr_en_i     ((state_q == S_RDATA) && beat_fire),
      .wr_idx_i    (beat_q),
      .wr_data_i   (RDATA),
      .inval_i     (state_q == S_AR),
      .set_valid_i (lb_set),
      .set_tag_i   (pc_q[ADDR_W-1:LINE_OFF]),
      .rd_pc_i     (req_pc),
      .hit_o       (lb_hit),
      .rd_word_o   (lb_word)
   );

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q      <= S_IDLE;
         arvalid_q    <= 1'b0;
         rready_q     <= 1'b0;
         araddr_q     <= '0;
         pc_q         <= '0;
         beat_q       <= '0;
         pend_q       <= 1'b0;
         err_q        <= 1'b0;
         carry_q      <= 1'b0;
         flush_seen_q <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_err_q    <= 1'b0;
         rsp_instr_q  <= '0;
         rsp_pc_q     <= '0;
      end else begin
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_instr_q <= '0;
         rsp_pc_q    <= '0;
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  if (req_pc[1:0] != 2'b00) begin
                     rsp_valid_q <= 1'b1;
                     rsp_err_q   <= 1'b1;
                     rsp_pc_q    <= req_pc;
                     carry_q     <= 1'b0;
                  end
`ifdef AXI_FETCH_LINEBUF_EN
                  else if (lb_hit) begin
                     rsp_valid_q <= 1'b1;
                     rsp_instr_q <= lb_word;
                     rsp_err_q   <= carry_q;
                     rsp_pc_q    <= req_pc;
                     carry_q     <= 1'b0;
                  end
`endif
                  else begin
                     state_q      <= S_AR;
                     arvalid_q    <= 1'b1;
                     araddr_q     <= req_pc & ~LINE_MASK;
                     pc_q         <= req_pc;
                     beat_q       <= '0;
                     pend_q       <= 1'b1;
                     err_q        <= 1'b0;
                     flush_seen_q <= 1'b0;
                  end
               end
            end
            S_AR: begin
               // The address phase cannot be withdrawn; a flush only redirects to DRAIN.
               if (flush) flush_seen_q <= 1'b1;
               if (ARREADY) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  if (flush_seen_q || flush) begin
                     state_q <= S_DRAIN;
                     pend_q  <= 1'b0;
                  end else begin
                     state_q <= S_RDATA;
                  end
               end
            end
            S_RDATA: begin
               if (beat_fire) begin
                  beat_q <= RLAST ? '0 : beat_q + BEAT_W'(1);
                  if (beat_err) err_q <= 1'b1;
                  if (crit_hit) begin
                     rsp_valid_q <= 1'b1;
                     rsp_instr_q <= crit_word;
                     rsp_err_q   <= err_q | beat_err | carry_q;
                     rsp_pc_q    <= pc_q;
                     carry_q     <= 1'b0;
                     pend_q      <= 1'b0;
                  end else if (beat_err && !pend_q) begin
                     carry_q <= 1'b1;
                  end
               end
               if (flush) begin
                  state_q <= S_DRAIN;
                  pend_q  <= 1'b0;
               end
               if (beat_fire && RLAST) begin
                  state_q  <= S_IDLE;
                  rready_q <= 1'b0;
                  pend_q   <= 1'b0;
               end
            end
            S_DRAIN: begin
               if (beat_fire) begin
                  beat_q <= RLAST ? '0 : beat_q + BEAT_W'(1);
                  if (RLAST) begin
                     state_q  <= S_IDLE;
                     rready_q <= 1'b0;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign ARVALID   = arvalid_q;
   assign ARADDR    = araddr_q;
   assign ARLEN     = arvalid_q ? 8'(BURST_LEN - 1) : 8'd0;
   assign ARSIZE    = arvalid_q ? size_enc(DATA_W) : 3'd0;
   assign ARBURST   = arvalid_q ? AXI_BURST_INCR : 2'b00;
   assign ARID      = arvalid_q ? ID_W'(FETCH_ID) : '0;
   assign RREADY    = rready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_instr = rsp_instr_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_pc    = rsp_pc_q;

endmodule

// File: tb/tb_axi_fetch_master.sv
// Directed bench for axi_fetch_master with a line-level reference model and
// a per-cycle compare process; honours AXI_FETCH_LINEBUF_EN when defined.
module tb_axi_fetch_master;

`ifdef AXI_FETCH_LINEBUF_EN
   localparam bit LB_EN = 1'b1;
`else
   localparam bit LB_EN = 1'b0;
`endif

   typedef struct {
      int          cyc;
      logic [63:0] pc;
      logic [31:0] instr;
      logic        err;
   } rsp_t;

   logic        clk, rstn, req_valid, req_ready, flush;
   logic [63:0] req_pc, rsp_pc, ARADDR, RDATA;
   logic        rsp_valid, rsp_err, ARVALID, ARREADY, RLAST, RVALID, RREADY;
   logic [31:0] rsp_instr;
   logic [3:0]  ARID, RID;
   logic [7:0]  ARLEN;
   logic [2:0]  ARSIZE;
   logic [1:0]  ARBURST, RRESP;

   int          cyc = 0, pass_cnt = 0, tot_cnt = 0, ar_cnt = 0;
   bit          chk_en = 0;
   logic        exp_req_ready = 1'b1, exp_arvalid = 1'b0, exp_rready = 1'b0;
   rsp_t        rsp_q[$];
   logic [63:0] ar_q[$];
   logic [63:0] last_araddr = '0;
   logic [31:0] last_instr = '0;
   logic        last_err = 1'b0;

   // Reference line-buffer model: what a clean fill left behind.
   logic        mdl_valid = 1'b0;
   logic [63:0] mdl_base = '0;
   logic [63:0] mdl_line [4];
   logic [63:0] bdat [4];
   logic [1:0]  bresp [4];

   axi_fetch_master dut (
      .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
      .flush(flush), .rsp_valid(rsp_valid), .rsp_instr(rsp_instr), .rsp_pc(rsp_pc), .rsp_err(rsp_err),
      .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
      .ARVALID(ARVALID), .ARREADY(ARREADY), .RID(RID), .RDATA(RDATA), .RRESP(RRESP),
      .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tot_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] word_of(input logic [63:0] d, input logic [63:0] pc);
      return pc[2] ? d[63:32] : d[31:0];
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         chk("req_ready", {63'd0, req_ready}, {63'd0, exp_req_ready});
         chk("ARVALID", {63'd0, ARVALID}, {63'd0, exp_arvalid});
         chk("RREADY", {63'd0, RREADY}, {63'd0, exp_rready});
         if (ARVALID) begin
            if (ar_q.size() == 0) chk("ar_unexpected", {63'd0, ARVALID}, 64'd0);
            else begin
               chk("ARADDR", ARADDR, ar_q[0]);
               chk("ARLEN", {56'd0, ARLEN}, 64'd3);
               chk("ARSIZE", {61'd0, ARSIZE}, 64'd3);
               chk("ARBURST", {62'd0, ARBURST}, 64'd1);
               chk("ARID", {60'd0, ARID}, 64'd0);
               if (ARREADY) begin
                  last_araddr = ARADDR;
                  ar_cnt++;
                  void'(ar_q.pop_front());
               end
            end
         end
         if (rsp_valid) begin
            if (rsp_q.size() == 0) chk("rsp_unexpected", {63'd0, rsp_valid}, 64'd0);
            else begin
               rsp_t e;
               e = rsp_q.pop_front();
               chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
               chk("rsp_pc", rsp_pc, e.pc);
               chk("rsp_instr", {32'd0, rsp_instr}, {32'd0, e.instr});
               chk("rsp_err", {63'd0, rsp_err}, {63'd0, e.err});
               last_instr = rsp_instr;
               last_err   = rsp_err;
            end
         end else begin
            chk("rsp_instr_idle", {32'd0, rsp_instr}, 64'd0);
            chk("rsp_err_idle", {63'd0, rsp_err}, 64'd0);
            if (rsp_q.size() > 0 && rsp_q[0].cyc <= cyc) begin
               chk("rsp_valid_missing", {63'd0, rsp_valid}, 64'd1);
               void'(rsp_q.pop_front());
            end
         end
      end
   end

   // One fetch: misaligned, (optional) line-buffer hit, or a full 4-beat fill
   // using bdat/bresp, with an optional flush on beat flush_at.
   task automatic fetch(input logic [63:0] pc, input int flush_at, input int ar_wait);
      logic [63:0] base;
      int          crit;
      logic        err, clean;
      base = pc & ~64'h1F;
      crit = int'((pc >> 3) & 64'h3);
      req_valid = 1'b1;
      req_pc    = pc;
      if (pc[1:0] != 2'b00) begin
         rsp_q.push_back('{cyc + 1, pc, 32'd0, 1'b1});
         step;
         req_valid = 1'b0;
         return;
      end
      if (LB_EN && mdl_valid && mdl_base == base) begin
         rsp_q.push_back('{cyc + 1, pc, word_of(mdl_line[crit], pc), 1'b0});
         step;
         req_valid = 1'b0;
         return;
      end
      ar_q.push_back(base);
      step;
      req_valid = 1'b0;
      exp_req_ready = 1'b0;
      exp_arvalid   = 1'b1;
      repeat (ar_wait) step;
      ARREADY = 1'b1;
      step;
      ARREADY = 1'b0;
      exp_arvalid = 1'b0;
      exp_rready  = 1'b1;
      err   = 1'b0;
      clean = (flush_at < 0);
      for (int i = 0; i < 4; i++) begin
         RVALID = 1'b1;
         RDATA  = bdat[i];
         RRESP  = bresp[i];
         RLAST  = (i == 3);
         flush  = (i == flush_at);
         if (bresp[i] != 2'b00) begin
            if (i <= crit) err = 1'b1;
            clean = 1'b0;
         end
         if (i == crit && (flush_at < 0 || i < flush_at))
            rsp_q.push_back('{cyc + 1, pc, word_of(bdat[i], pc), err});
         step;
      end
      RVALID = 1'b0; RLAST = 1'b0; flush = 1'b0; RDATA = '0; RRESP = 2'b00;
      exp_rready    = 1'b0;
      exp_req_ready = 1'b1;
      mdl_valid = clean;
      mdl_base  = base;
      for (int i = 0; i < 4; i++) mdl_line[i] = bdat[i];
   endtask

   initial begin
      int ar_before;
      rstn = 1'b0; req_valid = 1'b0; req_pc = '0; flush = 1'b0; ARREADY = 1'b0;
      RID = '0; RDATA = '0; RRESP = 2'b00; RLAST = 1'b0; RVALID = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bresp[i] = 2'b00;
         mdl_line[i] = '0;
      end
      repeat (2) step;
      chk_en = 1'b1;
      chk("rst_araddr", ARADDR, 64'd0);
      chk("rst_rsp_pc", rsp_pc, 64'd0);
      step;
      rstn = 1'b1;
      step;

      // Miss: pc 0x8000_0014 -> line 0x8000_0000, critical beat 2, upper word.
      bdat = '{64'hA0A0_0000_A0A0_0001, 64'hB0B0_0000_B0B0_0001,
               64'h1111_2222_3333_4444, 64'hD0D0_0000_D0D0_0001};
      fetch(64'h8000_0014, -1, 2);
      chk("lit_araddr", last_araddr, 64'h8000_0000);
      chk("lit_instr", {32'd0, last_instr}, 64'h1111_2222);
      repeat (2) step;

      // Same line again: hit with the line buffer, fresh AR burst otherwise.
      ar_before = ar_cnt;
      bdat = '{64'h1, 64'h2, 64'h3, 64'h5555_6666_7777_8888};
      fetch(64'h8000_0018, -1, 0);
      repeat (2) step;
      chk("lit_word_0x18", {32'd0, last_instr}, LB_EN ? 64'hD0D0_0001 : 64'h7777_8888);
      chk("ar_count_0x18", 64'(ar_cnt - ar_before), LB_EN ? 64'd0 : 64'd1);

      // SLVERR on the critical beat, then the same pc must refetch over AXI.
      bdat  = '{64'h10, 64'h20, 64'hCAFE_F00D_0BAD_BEEF, 64'h40};
      bresp = '{2'b00, 2'b00, 2'b10, 2'b00};
      fetch(64'h8000_0034, -1, 1);
      chk("lit_err", {63'd0, last_err}, 64'd1);
      bresp = '{default: 2'b00};
      ar_before = ar_cnt;
      fetch(64'h8000_0034, -1, 0);
      repeat (2) step;
      chk("refetch_ar", 64'(ar_cnt - ar_before), 64'd1);
      chk("refetch_instr", {32'd0, last_instr}, 64'hCAFE_F00D);

      // Misaligned pc: immediate error response, no AR.
      ar_before = ar_cnt;
      fetch(64'h8000_0002, -1, 0);
      repeat (3) step;
      chk("mis_err", {63'd0, last_err}, 64'd1);
      chk("mis_no_ar", 64'(ar_cnt - ar_before), 64'd0);

      // Flush at beat 1 of 4: no response, drain to RLAST, then ready again.
      bdat = '{64'h1234, 64'h5678, 64'h9999_AAAA_BBBB_CCCC, 64'hDDDD};
      fetch(64'h8000_0014, 1, 0);
      repeat (2) step;
      bdat = '{64'h0, 64'h0, 64'h0102_0304_0506_0708, 64'h0};
      fetch(64'h8000_0010, -1, 0);
      repeat (2) step;
      chk("post_flush_instr", {32'd0, last_instr}, 64'h0506_0708);

      // Reset for 2 cycles in the middle of a burst.
      req_valid = 1'b1; req_pc = 64'h8000_0058;
      ar_q.push_back(64'h8000_0040);
      step;
      req_valid = 1'b0; exp_req_ready = 1'b0; exp_arvalid = 1'b1;
      ARREADY = 1'b1;
      step;
      ARREADY = 1'b0; exp_arvalid = 1'b0; exp_rready = 1'b1;
      RVALID = 1'b1; RDATA = 64'hFFFF;
      step;
      RVALID = 1'b0; RDATA = '0;
      rstn = 1'b0;
      step;
      exp_rready = 1'b0; exp_req_ready = 1'b1; mdl_valid = 1'b0;
      step;
      chk("rst2_araddr", ARADDR, 64'd0);
      rstn = 1'b1;
      step;
      bdat = '{64'h0, 64'h0, 64'h0, 64'hABCD_0000_1357_2468};
      fetch(64'h8000_005C, -1, 0);
      repeat (3) step;
      chk("post_rst_instr", {32'd0, last_instr}, 64'hABCD_0000);
      chk("rsp_q_empty", 64'(rsp_q.size()), 64'd0);
      chk("ar_q_empty", 64'(ar_q.size()), 64'd0);

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule

// File: doc/axi_fetch_master.md
AXI_FETCH_MASTER -- requirements
Module: axi_fetch_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, fetch/AXI address width.
REQ-002 SHALL have parameter DATA_W, default 64, R-channel data width (64 or 128).
REQ-003 SHALL have parameter BURST_LEN, default 4, beats per line fill (1, 2, 4, 8).
REQ-004 SHALL have parameter ID_W, default 4, and FETCH_ID, default 0, the ARID value.
REQ-005 SHALL have port clk, input, 1, clock; all logic rising-edge.
REQ-006 SHALL have port rstn, input, 1, reset, synchronous, active-low.
REQ-007 SHALL have ports req_valid in 1, req_ready out 1, req_pc in ADDR_W: fetch request handshake.
REQ-008 SHALL have port flush, input, 1, cancel any pending fetch (taken jump).
REQ-009 SHALL have ports rsp_valid out 1, rsp_instr out 32, rsp_pc out ADDR_W, rsp_err out 1: one-cycle response.
REQ-010 SHALL have AR ports ARID out ID_W, ARADDR out ADDR_W, ARLEN out 8, ARSIZE out 3, ARBURST out 2, ARVALID out 1, ARREADY in 1.
REQ-011 SHALL have R ports RID in ID_W, RDATA in DATA_W, RRESP in 2, RLAST in 1, RVALID in 1, RREADY out 1.

Function
REQ-012 SHALL use FSM states IDLE, AR, RDATA, DRAIN; reset state IDLE.
REQ-013 SHALL drive req_ready = (state==IDLE) && !flush; request accepted on req_valid && req_ready.
REQ-014 SHALL answer an accepted req_pc with req_pc[1:0]!=0 next cycle: rsp_valid=1, rsp_err=1, no AXI traffic.
REQ-015 SHALL on miss enter AR next cycle with ARADDR = req_pc aligned down to line size BURST_LEN*DATA_W/8, ARLEN=BURST_LEN-1, ARSIZE=log2(DATA_W/8), ARBURST=2'b01, ARID=FETCH_ID.
REQ-016 SHALL hold ARVALID and all AR fields stable until ARREADY, even under flush; then enter RDATA (DRAIN if flush seen during AR).
REQ-017 SHALL drive RREADY=1 exactly in RDATA and DRAIN; RID not checked.
REQ-018 SHALL store each beat into line buffer slot given by beat counter (0..BURST_LEN-1, wraps to 0 on RLAST).
REQ-019 SHALL pulse rsp_valid one cycle after the beat holding req_pc arrives (critical word), rsp_instr = 32-bit word selected by req_pc[log2(DATA_W/8)-1:2].
REQ-020 SHALL return to IDLE on the RLAST beat; further requests wait until then.
REQ-021 SHALL on flush in RDATA go to DRAIN, suppress any not-yet-issued rsp, discard beats until RLAST, then IDLE; flush in DRAIN/IDLE has no further effect.
REQ-022 SHALL on any beat with RRESP!=2'b00 set rsp_err=1 on the pending response (or next if already sent) and invalidate line buffer at RLAST.
REQ-023 SHALL drive rsp_instr=0, rsp_err=0 whenever rsp_valid=0.

Reset
REQ-024 SHALL on rstn=0 force state IDLE, ARVALID=0, RREADY=0, rsp_valid=0, rsp_err=0, all data outputs 0, beat counter 0, line buffer invalid.
REQ-025 SHALL abandon mid-burst state on reset without tracking outstanding AXI beats.

Configuration
REQ-026 SHALL with AXI_FETCH_LINEBUF_EN defined answer requests whose line tag matches a valid line buffer with rsp next cycle, no AXI transaction.
REQ-027 SHALL without AXI_FETCH_LINEBUF_EN issue an AR burst for every aligned request; line buffer used only for critical-word capture.

Structure
REQ-028 SHALL place FSM state enum, AXI burst/resp encodings and line-size constants in package axi_fetch_pkg.
REQ-029 SHALL implement line storage plus tag/valid as sub-module fetch_line_buf; FSM and AXI logic in axi_fetch_master.

Verification
REQ-030 SHALL cover reset: rstn=0 for 2 cycles mid-RDATA -> ARVALID=0, RREADY=0, rsp_valid=0, state IDLE.
REQ-031 SHALL cover miss: req_pc=0x8000_0014, ARREADY=1 -> ARADDR=0x8000_0000, ARLEN=3, ARSIZE=3; beat 2 RDATA=0x1111_2222_3333_4444 -> rsp_instr=0x1111_2222.
REQ-032 SHALL cover flush at beat 1 of 4 -> no rsp_valid, RREADY held until RLAST, req_ready=1 cycle after.
REQ-033 SHALL cover error: RRESP=2'b10 on critical beat -> rsp_valid=1, rsp_err=1; repeat req_pc refetches over AXI.
REQ-034 SHALL cover misaligned req_pc=0x8000_0002 -> rsp_err=1 next cycle, ARVALID stays 0.
REQ-035 SHALL cover, with AXI_FETCH_LINEBUF_EN, req_pc=0x8000_0018 after fill of 0x8000_0000 -> rsp next cycle, ARVALID stays 0.
